// File: rtl/malvar_demosaic_stream.sv
// Streaming Malvar-He-Cutler Bayer demosaic over a 5x5 mirror-padded window.
// Each output pixel is emitted two rows plus two pixels after its raw input.
module malvar_demosaic_stream #(
    parameter int BIT_WIDTH     = 8,
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int BAYER_PATTERN = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   in_pixel,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*BIT_WIDTH-1:0] out_rgb,
    output logic                   out_sof,
    output logic                   out_eol
);
    localparam int DEPTH = 4 * WIDTH + 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(WIDTH * HEIGHT + 1);
    localparam int FW    = $clog2(2 * WIDTH + 3);
    localparam int RW    = $clog2(HEIGHT);
    localparam int XW    = $clog2(WIDTH);
    localparam int SW    = BIT_WIDTH + 8;
    localparam logic G_PAR = (BAYER_PATTERN == 0) || (BAYER_PATTERN == 3);
    localparam logic R_ROW = (BAYER_PATTERN < 2);
    localparam logic signed [SW-1:0] MAX_V = SW'((1 << BIT_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t state, state_next;
    logic ready_en, out_free, in_acc, sof_acc, flush_step, step_out, shift;
    logic [BIT_WIDTH-1:0] cur;
    logic [CW-1:0] in_cnt;
    logic [FW-1:0] fl_cnt;
    logic [RW-1:0] orow;
    logic [XW-1:0] ocol;
    logic [BIT_WIDTH-1:0] line_buf [DEPTH];

    assign out_free   = !out_valid || out_ready;
    assign in_acc     = in_valid && in_ready;
    assign sof_acc    = in_acc && in_sof;
    assign flush_step = (state == FLUSH) && out_free && !sof_acc;
    assign step_out   = ((state == RUN) && in_acc && !in_sof) || flush_step;
    assign shift      = (in_acc && ((state != IDLE) || in_sof)) || flush_step;
    assign cur        = flush_step ? '0 : in_pixel;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        if (sof_acc) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (in_acc && in_cnt == CW'(2 * WIDTH + 1)) state_next = RUN;
                RUN:     if (in_acc && in_cnt == CW'(WIDTH * HEIGHT - 1)) state_next = FLUSH;
                FLUSH:   if (flush_step && fl_cnt == FW'(2 * WIDTH + 1)) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // A new frame start may cut a stalled flush short, hence in_sof opens the FLUSH gate.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:        in_ready = 1'b1;
            FILL, RUN:   in_ready = out_free;
            FLUSH:       in_ready = in_sof;
            default:     in_ready = 1'b0;
        endcase
        if (!ready_en) in_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt <= '0;
            fl_cnt <= '0;
            orow   <= '0;
            ocol   <= '0;
        end else if (sof_acc) begin
            in_cnt <= CW'(1);
            fl_cnt <= '0;
            orow   <= '0;
            ocol   <= '0;
        end else begin
            if (in_acc && (state == FILL || state == RUN)) in_cnt <= in_cnt + CW'(1);
            if (flush_step) fl_cnt <= fl_cnt + FW'(1);
            if (step_out) begin
                if (ocol == XW'(WIDTH - 1)) begin
                    ocol <= '0;
                    orow <= (orow == RW'(HEIGHT - 1)) ? '0 : orow + RW'(1);
                end else begin
                    ocol <= ocol + XW'(1);
                end
            end
        end
    end

    // NOTE: the line buffer is pure data storage and is not reset; FILL rewrites it before any use.
    always_ff @(posedge clk) begin
        if (shift) begin
            line_buf[0] <= cur;
            for (int i = 1; i < DEPTH; i++) line_buf[i] <= line_buf[i-1];
        end
    end

    function automatic int row_off(input int r, input int d);
        int t;
        t = r + d;
        if (t < 0) t = -t;
        else if (t > HEIGHT - 1) t = 2 * (HEIGHT - 1) - t;
        return t - r;
    endfunction

    function automatic int col_off(input int c, input int d);
        int t;
        t = c + d;
        if (t < 0) t = -t;
        else if (t > WIDTH - 1) t = 2 * (WIDTH - 1) - t;
        return t - c;
    endfunction

    // Offset 0 is the sample arriving now; the centre sits 2*WIDTH+2 samples back.
    function automatic logic signed [SW-1:0] tap(input int dr, input int dc);
        int off;
        off = 2 * WIDTH + 2 - row_off(int'(orow), dr) * WIDTH - col_off(int'(ocol), dc);
        if (off == 0) return $signed({8'd0, cur});
        return $signed({8'd0, line_buf[AW'(off - 1)]});
    endfunction

    function automatic logic [BIT_WIDTH-1:0] clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
        q = (s + SW'(8)) >>> 4;
        if (q < 0) return '0;
        if (q > MAX_V) return '1;
        return q[BIT_WIDTH-1:0];
    endfunction

    logic signed [SW-1:0] t_c, t_n, t_s, t_e, t_w, t_nn, t_ss, t_ee, t_ww, t_dg;
    logic signed [SW-1:0] k_g, k_x, k_row, k_col;
    logic [BIT_WIDTH-1:0] r_v, g_v, b_v;
    logic is_g, on_r_row;

    always_comb begin
        t_c  = tap(0, 0);
        t_n  = tap(-1, 0);
        t_s  = tap(1, 0);
        t_w  = tap(0, -1);
        t_e  = tap(0, 1);
        t_nn = tap(-2, 0);
        t_ss = tap(2, 0);
        t_ww = tap(0, -2);
        t_ee = tap(0, 2);
        t_dg = tap(-1, -1) + tap(-1, 1) + tap(1, -1) + tap(1, 1);
        k_g   = (t_c <<< 3) + ((t_n + t_s + t_e + t_w) <<< 2)
              - ((t_nn + t_ss + t_ee + t_ww) <<< 1);
        k_x   = (t_c <<< 3) + (t_c <<< 2) + (t_dg <<< 2)
              - (((t_nn + t_ss + t_ee + t_ww) <<< 1) + (t_nn + t_ss + t_ee + t_ww));
        k_row = (t_c <<< 3) + (t_c <<< 1) + ((t_w + t_e) <<< 3)
              - ((t_ww + t_ee + t_dg) <<< 1) + t_nn + t_ss;
        k_col = (t_c <<< 3) + (t_c <<< 1) + ((t_n + t_s) <<< 3)
              - ((t_nn + t_ss + t_dg) <<< 1) + t_ww + t_ee;
    end

    assign is_g     = ((orow[0] ^ ocol[0]) == G_PAR);
    assign on_r_row = (orow[0] == R_ROW);

    always_comb begin
        r_v = t_c[BIT_WIDTH-1:0];
        g_v = t_c[BIT_WIDTH-1:0];
        b_v = t_c[BIT_WIDTH-1:0];
        if (!is_g) begin
            g_v = clamp(k_g);
            if (on_r_row) b_v = clamp(k_x);
            else          r_v = clamp(k_x);
        end else if (on_r_row) begin
            r_v = clamp(k_row);
            b_v = clamp(k_col);
        end else begin
            b_v = clamp(k_row);
            r_v = clamp(k_col);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (sof_acc && state != IDLE) begin
            out_valid <= 1'b0;
        end else if (step_out) begin
            out_valid <= 1'b1;
            out_rgb   <= {r_v, g_v, b_v};
            out_sof   <= (orow == '0) && (ocol == '0);
            out_eol   <= (ocol == XW'(WIDTH - 1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
